// File: rtl/blocky_move_ctrl_if.sv
// Request/done channel between the Blocky movement controller and the VGA square drawer.
// The controller (master) presents op and position while draw_req is high; the drawer pulses draw_done.
interface blocky_move_ctrl_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           draw_req;
    logic [1:0]     draw_op;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic           draw_done;

    modport master (output draw_req, draw_op, pos_x, pos_y, input draw_done);
    modport slave  (input draw_req, draw_op, pos_x, pos_y, output draw_done);
endinterface

// File: rtl/blocky_move_ctrl.sv
// Player-square movement controller for Blocky: key auto-repeat, playfield clamping, clear/erase/draw sequencing.
// Define BLOCKY_DIAGONAL_EN to latch vertical and horizontal keys independently (diagonal steps).
module blocky_move_ctrl #(
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int X_MAX        = 159,
    parameter int Y_MAX        = 119,
    parameter int SIZE         = 4,
    parameter int STEP         = 1,
    parameter int X_START      = 78,
    parameter int Y_START      = 58,
    parameter int REPEAT_DELAY = 2500000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               restart,
    input  logic               start,
    input  logic               key_w,
    input  logic               key_s,
    input  logic               key_a,
    input  logic               key_d,
    output logic               busy,
    blocky_move_ctrl_if.master draw_if
);
    localparam int              CNT_W    = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [X_W:0]    X_STEP   = (X_W+1)'(STEP);
    localparam logic [Y_W:0]    Y_STEP   = (Y_W+1)'(STEP);
    localparam logic [X_W:0]    X_LIM    = (X_W+1)'(X_MAX + 1 - SIZE);
    localparam logic [Y_W:0]    Y_LIM    = (Y_W+1)'(Y_MAX + 1 - SIZE);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_DRAW  = 2'b11;

    typedef enum logic [3:0] {
        S_SETUP, S_CLEAR, S_DRAW_INIT, S_IDLE, S_WAIT_MOVE,
        S_ERASE, S_UPDATE, S_DRAW, S_HOLD
    } state_t;

    state_t           state_q;
    logic             draw_req_q;
    logic [1:0]       draw_op_q;
    logic [X_W-1:0]   pos_x_q, pos_x_d;
    logic [Y_W-1:0]   pos_y_q, pos_y_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       dir_q, dir_d;   // {up, down, left, right}
    logic [3:0]       keys;

    // Sums/differences are one bit wider than the coordinate so they never wrap before clamping.
    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic dec, input logic inc);
        logic [X_W:0] wide;
        wide   = '0;
        step_x = x;
        if (dec) begin
            wide   = {1'b0, x} - X_STEP;
            step_x = ({1'b0, x} < X_STEP) ? '0 : wide[X_W-1:0];
        end else if (inc) begin
            wide   = {1'b0, x} + X_STEP;
            step_x = (wide > X_LIM) ? X_LIM[X_W-1:0] : wide[X_W-1:0];
        end
    endfunction

    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic dec, input logic inc);
        logic [Y_W:0] wide;
        wide   = '0;
        step_y = y;
        if (dec) begin
            wide   = {1'b0, y} - Y_STEP;
            step_y = ({1'b0, y} < Y_STEP) ? '0 : wide[Y_W-1:0];
        end else if (inc) begin
            wide   = {1'b0, y} + Y_STEP;
            step_y = (wide > Y_LIM) ? Y_LIM[Y_W-1:0] : wide[Y_W-1:0];
        end
    endfunction

    assign keys = {key_w, key_s, key_a, key_d};

    always_comb begin
        dir_d = 4'b0000;
`ifdef BLOCKY_DIAGONAL_EN
        if (key_w)      dir_d[3] = 1'b1;
        else if (key_s) dir_d[2] = 1'b1;
        if (key_a)      dir_d[1] = 1'b1;
        else if (key_d) dir_d[0] = 1'b1;
`else
        if (key_w)      dir_d = 4'b1000;
        else if (key_s) dir_d = 4'b0100;
        else if (key_a) dir_d = 4'b0010;
        else if (key_d) dir_d = 4'b0001;
`endif
        pos_x_d = step_x(pos_x_q, dir_q[1], dir_q[0]);
        pos_y_d = step_y(pos_y_q, dir_q[3], dir_q[2]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_SETUP;
            draw_req_q <= 1'b0;
            draw_op_q  <= OP_IDLE;
            pos_x_q    <= X_W'(X_START);
            pos_y_q    <= Y_W'(Y_START);
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            dir_q      <= '0;
        end else if (restart) begin
            state_q    <= S_SETUP;
            draw_req_q <= 1'b0;
            draw_op_q  <= OP_IDLE;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_SETUP: begin
                    pos_x_q    <= X_W'(X_START);
                    pos_y_q    <= Y_W'(Y_START);
                    state_q    <= S_CLEAR;
                    draw_req_q <= 1'b1;
                    draw_op_q  <= OP_CLEAR;
                    busy_q     <= 1'b1;
                end
                S_CLEAR: if (draw_req_q && draw_if.draw_done) begin
                    draw_req_q <= 1'b0;
                    draw_op_q  <= OP_IDLE;
                    state_q    <= S_DRAW_INIT;
                end
                // Entered right after a completed request, so req is re-raised one cycle later.
                S_DRAW_INIT: begin
                    if (!draw_req_q) begin
                        draw_req_q <= 1'b1;
                        draw_op_q  <= OP_DRAW;
                    end else if (draw_if.draw_done) begin
                        draw_req_q <= 1'b0;
                        draw_op_q  <= OP_IDLE;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                S_IDLE: if (start) state_q <= S_WAIT_MOVE;
                S_WAIT_MOVE: if (|keys) begin
                    dir_q      <= dir_d;
                    state_q    <= S_ERASE;
                    draw_req_q <= 1'b1;
                    draw_op_q  <= OP_ERASE;
                    busy_q     <= 1'b1;
                end
                S_ERASE: if (draw_req_q && draw_if.draw_done) begin
                    draw_req_q <= 1'b0;
                    draw_op_q  <= OP_IDLE;
                    state_q    <= S_UPDATE;
                end
                S_UPDATE: begin
                    pos_x_q    <= pos_x_d;
                    pos_y_q    <= pos_y_d;
                    state_q    <= S_DRAW;
                    draw_req_q <= 1'b1;
                    draw_op_q  <= OP_DRAW;
                end
                S_DRAW: if (draw_req_q && draw_if.draw_done) begin
                    draw_req_q <= 1'b0;
                    draw_op_q  <= OP_IDLE;
                    state_q    <= S_HOLD;
                    cnt_q      <= '0;
                end
                S_HOLD: begin
                    if ((dir_q & keys) == 4'b0000) begin
                        state_q <= S_WAIT_MOVE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
`ifdef BLOCKY_DIAGONAL_EN
                        dir_q <= dir_d;
`endif
                        state_q    <= S_ERASE;
                        cnt_q      <= '0;
                        draw_req_q <= 1'b1;
                        draw_op_q  <= OP_ERASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_SETUP;
                    draw_req_q <= 1'b0;
                    draw_op_q  <= OP_IDLE;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign draw_if.draw_req = draw_req_q;
    assign draw_if.draw_op  = draw_op_q;
    assign draw_if.pos_x    = pos_x_q;
    assign draw_if.pos_y    = pos_y_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_blocky_move_ctrl.sv
// Directed bench for blocky_move_ctrl: a scoreboard of expected drawer requests, served by an in-bench drawer.
module tb_blocky_move_ctrl;
    localparam int X_W = 8, Y_W = 7, X_MAX = 159, Y_MAX = 119, SIZE = 4, STEP = 1;
    localparam int XS = 78, YS = 58, RD = 10;

    typedef struct packed {
        logic [1:0]     op;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } req_t;

    logic clk = 1'b0;
    logic resetn = 1'b1, restart = 1'b0, start = 1'b0;
    logic key_w = 1'b0, key_s = 1'b0, key_a = 1'b0, key_d = 1'b0;
    logic busy;
    req_t sb[$];
    int   passed = 0, total = 0;
    int   mx, my, n;

    blocky_move_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) dif ();

    blocky_move_ctrl #(
        .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SIZE(SIZE), .STEP(STEP),
        .X_START(XS), .Y_START(YS), .REPEAT_DELAY(RD)
    ) dut (
        .clk(clk), .resetn(resetn), .restart(restart), .start(start),
        .key_w(key_w), .key_s(key_s), .key_a(key_a), .key_d(key_d),
        .busy(busy), .draw_if(dif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push(input logic [1:0] op, input int x, input int y);
        req_t e;
        e.op = op; e.x = X_W'(x); e.y = Y_W'(y);
        sb.push_back(e);
    endtask

    // Wait for a request, compare it with the scoreboard head, answer done 3 cycles later.
    task automatic serve(input string tag);
        req_t e;
        int   k;
        k = 0;
        while (dif.draw_req !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " req"}, dif.draw_req, 1);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, " op"}, dif.draw_op, e.op);
        chk({tag, " x"}, dif.pos_x, e.x);
        chk({tag, " y"}, dif.pos_y, e.y);
        chk({tag, " busy"}, busy, 1);
        repeat (3) @(negedge clk);
        chk({tag, " op stable"}, dif.draw_op, e.op);
        dif.draw_done = 1'b1;
        @(negedge clk);
        dif.draw_done = 1'b0;
        chk({tag, " req drop"}, dif.draw_req, 0);
    endtask

    // One tapped move: model the expected position, expect erase(old)+draw(new), then release.
    task automatic move(input logic w, input logic s, input logic a, input logic d);
        int nx, ny;
        nx = mx; ny = my;
        if (w)      ny = (my < STEP) ? 0 : my - STEP;
        else if (s) ny = (my + STEP > Y_MAX + 1 - SIZE) ? Y_MAX + 1 - SIZE : my + STEP;
`ifdef BLOCKY_DIAGONAL_EN
        if (a)      nx = (mx < STEP) ? 0 : mx - STEP;
        else if (d) nx = (mx + STEP > X_MAX + 1 - SIZE) ? X_MAX + 1 - SIZE : mx + STEP;
`else
        if (!w && !s) begin
            if (a)      nx = (mx < STEP) ? 0 : mx - STEP;
            else if (d) nx = (mx + STEP > X_MAX + 1 - SIZE) ? X_MAX + 1 - SIZE : mx + STEP;
        end
`endif
        push(2'b10, mx, my);
        push(2'b11, nx, ny);
        {key_w, key_s, key_a, key_d} = {w, s, a, d};
        serve("erase");
        serve("draw");
        mx = nx; my = ny;
        {key_w, key_s, key_a, key_d} = 4'b0000;
        @(negedge clk);
        chk("move busy", busy, 0);
        chk("move pos_x", dif.pos_x, mx);
        chk("move pos_y", dif.pos_y, my);
    endtask

    initial begin
        dif.draw_done = 1'b0;
        #1 resetn = 1'b0;
        #2;
        chk("reset req", dif.draw_req, 0);
        chk("reset op", dif.draw_op, 0);
        chk("reset x", dif.pos_x, XS);
        chk("reset y", dif.pos_y, YS);
        chk("reset busy", busy, 1);

        mx = XS; my = YS;
        push(2'b01, XS, YS);
        push(2'b11, XS, YS);
        @(negedge clk);
        resetn = 1'b1;
        serve("clear");
        serve("init draw");
        @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle op", dif.draw_op, 0);
        start = 1'b1;
        @(negedge clk);
        chk("wait_move busy", busy, 0);

        // Held D with auto-repeat.
        push(2'b10, 78, 58);
        push(2'b11, 79, 58);
        key_d = 1'b1;
        serve("rep erase1");
        serve("rep draw1");
        n = 0;
        while (dif.draw_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("repeat delay", n, RD);
        push(2'b10, 79, 58);
        push(2'b11, 80, 58);
        serve("rep erase2");
        serve("rep draw2");
        key_d = 1'b0;
        @(negedge clk);
        chk("release busy", busy, 0);
        chk("release pos_x", dif.pos_x, 80);
        mx = 80;

        move(1'b1, 1'b1, 1'b0, 1'b0);   // W+S together
        move(1'b1, 1'b0, 1'b0, 1'b1);   // W+D together

        while (my > 0) move(1'b1, 1'b0, 1'b0, 1'b0);
        move(1'b1, 1'b0, 1'b0, 1'b0);   // clamp at top
        chk("top clamp y", dif.pos_y, 0);
        while (mx < X_MAX + 1 - SIZE) move(1'b0, 1'b0, 1'b0, 1'b1);
        move(1'b0, 1'b0, 1'b0, 1'b1);   // clamp at right
        chk("right clamp x", dif.pos_x, 156);

        // Restart during an erase request.
        key_a = 1'b1;
        n = 0;
        while (dif.draw_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre-restart op", dif.draw_op, 2);
        key_a = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        chk("restart req", dif.draw_req, 0);
        chk("restart op", dif.draw_op, 0);
        restart = 1'b0;
        dif.draw_done = 1'b1;
        @(negedge clk);
        dif.draw_done = 1'b0;
        mx = XS; my = YS;
        push(2'b01, XS, YS);
        push(2'b11, XS, YS);
        serve("rs clear");
        serve("rs init draw");
        @(negedge clk);
        chk("rs busy", busy, 0);

        // Asynchronous reset while holding a key in the hold phase.
        push(2'b10, XS, YS);
        push(2'b11, XS + 1, YS);
        key_d = 1'b1;
        serve("ar erase");
        serve("ar draw");
        @(negedge clk);
        @(negedge clk);
        chk("ar hold x", dif.pos_x, XS + 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar req", dif.draw_req, 0);
        chk("ar op", dif.draw_op, 0);
        chk("ar x", dif.pos_x, XS);
        chk("ar y", dif.pos_y, YS);
        chk("ar busy", busy, 1);
        key_d = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        push(2'b01, XS, YS);
        push(2'b11, XS, YS);
        serve("ar clear");
        serve("ar init draw");
        chk("scoreboard empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
